pe_stream_driver: RTL and testbench

- Initiator-side feeder for one PE; drives the PE's filter/ifmap/ipsum streams and sinks its opsum stream.
- Latches a 13-bit PE config and pulses pe_en to the PE.
- Fetches words from a global-buffer read port (1-cycle latency), presents them with valid/ready, then writes returned opsums to a global-buffer write port.
- Sits between the global buffer and one PE; later instanced per PE row by the array controller.

---
 rtl/pe_drv_pkg.sv | 46 ++++
 rtl/pe_word_tx.sv | 35 +++
 rtl/pe_stream_driver.sv | 201 ++++++++++++++++++++
 tb/tb_pe_stream_driver.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_drv_pkg.sv
// Shared definitions for the PE stream driver: FSM encoding, cfg field layout
// and the word counts derived from a latched cfg.
package pe_drv_pkg;

   localparam int CFG_W  = 13;
   localparam int DW_BIT = 12;
   localparam int RS_LSB = 10;
   localparam int U_BIT  = 9;
   localparam int P_LSB  = 7;
   localparam int F_LSB  = 2;
   localparam int Q_LSB  = 0;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_CFG     = 4'd1;
   localparam logic [3:0] S_FILT_RD = 4'd2;
   localparam logic [3:0] S_FILT_TX = 4'd3;
   localparam logic [3:0] S_IFM_RD  = 4'd4;
   localparam logic [3:0] S_IFM_TX  = 4'd5;
   localparam logic [3:0] S_IPS_RD  = 4'd6;
   localparam logic [3:0] S_IPS_TX  = 4'd7;
   localparam logic [3:0] S_OPS_RX  = 4'd8;
   localparam logic [3:0] S_DONE    = 4'd9;

   // Filter words per pass: p*rs, at most 4*4 = 16, so 5 bits never overflow.
   function automatic logic [4:0] cfg_nf(input logic [CFG_W-1:0] c);
      logic [4:0] p;
      logic [4:0] rs;
      p  = {3'd0, c[P_LSB +: 2]} + 5'd1;
      rs = {3'd0, c[RS_LSB +: 2]} + 5'd1;
      return p * rs;
   endfunction

   function automatic logic [2:0] cfg_np(input logic [CFG_W-1:0] c);
      return c[DW_BIT] ? ({1'b0, c[Q_LSB +: 2]} + 3'd1) : ({1'b0, c[P_LSB +: 2]} + 3'd1);
   endfunction

   // First column needs the full rs window; later columns slide by U.
   function automatic logic [2:0] cfg_ifm_words(input logic [CFG_W-1:0] c, input logic first_col);
      return first_col ? ({1'b0, c[RS_LSB +: 2]} + 3'd1) : ({2'd0, c[U_BIT]} + 3'd1);
   endfunction

   function automatic logic [4:0] cfg_last_col(input logic [CFG_W-1:0] c);
      return c[F_LSB +: 5];
   endfunction

endpackage

// File: rtl/pe_word_tx.sv
// One-word stream sender: presents a freshly read buffer word the cycle it arrives.
// Zero added latency; if ready is low the word is parked and held stable until accepted.
module pe_word_tx #(
   parameter int DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 valid,
   input  logic                 ready,
   output logic                 accepted
);

   logic                 held;
   logic [DATA_BITS-1:0] hold_q;

   assign valid    = load | held;
   assign dout     = held ? hold_q : (load ? din : '0);
   assign accepted = valid & ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held   <= 1'b0;
         hold_q <= '0;
      end else if (load && !ready) begin
         held   <= 1'b1;
         hold_q <= din;
      end else if (held && ready) begin
         held   <= 1'b0;
      end
   end

endmodule

// File: rtl/pe_stream_driver.sv
// Feeds one PE from the global buffer (filter, ifmap, ipsum streams) and writes its opsums back.
// 1-cycle buffer read latency, one word per 2 cycles; streams hold data/valid while ready is low.
module pe_stream_driver
   import pe_drv_pkg::*;
#(
   parameter int DATA_BITS   = 32,
   parameter int ADDR_W      = 16,
   parameter int CONFIG_SIZE = 13
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CONFIG_SIZE-1:0] cfg,
   input  logic [ADDR_W-1:0]      filter_base,
   input  logic [ADDR_W-1:0]      ifmap_base,
   input  logic [ADDR_W-1:0]      ipsum_base,
   input  logic [ADDR_W-1:0]      opsum_base,
   output logic                   busy,
   output logic                   done,
   output logic                   buf_rd_en,
   output logic [ADDR_W-1:0]      buf_rd_addr,
   input  logic [DATA_BITS-1:0]   buf_rd_data,
   output logic                   buf_wr_en,
   output logic [ADDR_W-1:0]      buf_wr_addr,
   output logic [DATA_BITS-1:0]   buf_wr_data,
   output logic                   pe_en,
   output logic [CONFIG_SIZE-1:0] pe_config,
   output logic [DATA_BITS-1:0]   filter,
   output logic [DATA_BITS-1:0]   ifmap,
   output logic [DATA_BITS-1:0]   ipsum,
   output logic                   filter_valid,
   output logic                   ifmap_valid,
   output logic                   ipsum_valid,
   input  logic                   filter_ready,
   input  logic                   ifmap_ready,
   input  logic                   ipsum_ready,
   input  logic [DATA_BITS-1:0]   opsum,
   input  logic                   opsum_valid,
   output logic                   opsum_ready
);

   logic [3:0]             state;
   logic [CONFIG_SIZE-1:0] cfg_q;
   logic [ADDR_W-1:0]      fbase_q, ibase_q, pbase_q, obase_q;
   logic [ADDR_W-1:0]      iidx;
   logic [ADDR_W-1:0]      col_off;
   logic [4:0]             fidx;
   logic [4:0]             col;
   logic [2:0]             k;
   logic                   rd_q;
   logic [4:0]             nf;
   logic [2:0]             np;
   logic [2:0]             ifm_n;
   logic                   f_acc, i_acc, p_acc;
   logic                   ops_wr;

   assign nf     = cfg_nf(cfg_q);
   assign np     = cfg_np(cfg_q);
   assign ifm_n  = cfg_ifm_words(cfg_q, col == 5'd0);
   assign ops_wr = (state == S_OPS_RX) && opsum_valid;

   assign busy        = (state != S_IDLE) && (state != S_DONE);
   assign done        = (state == S_DONE);
   assign pe_en       = (state == S_CFG);
   assign pe_config   = cfg_q;
   assign opsum_ready = (state == S_OPS_RX);
   assign buf_rd_en   = (state == S_FILT_RD) || (state == S_IFM_RD) || (state == S_IPS_RD);

   // ipsum and opsum share the same per-column layout: col*NP + k, kept as a running offset.
   always_comb begin
      buf_rd_addr = '0;
      case (state)
         S_FILT_RD: buf_rd_addr = fbase_q + ADDR_W'(fidx);
         S_IFM_RD:  buf_rd_addr = ibase_q + iidx;
         S_IPS_RD:  buf_rd_addr = pbase_q + col_off + ADDR_W'(k);
         default:   buf_rd_addr = '0;
      endcase
   end

   assign buf_wr_en   = ops_wr;
   assign buf_wr_addr = ops_wr ? (obase_q + col_off + ADDR_W'(k)) : '0;
   assign buf_wr_data = ops_wr ? opsum : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cfg_q   <= '0;
         fbase_q <= '0;
         ibase_q <= '0;
         pbase_q <= '0;
         obase_q <= '0;
         fidx    <= '0;
         iidx    <= '0;
         col     <= '0;
         col_off <= '0;
         k       <= '0;
         rd_q    <= 1'b0;
      end else begin
         rd_q <= buf_rd_en;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cfg_q   <= cfg;
                  fbase_q <= filter_base;
                  ibase_q <= ifmap_base;
                  pbase_q <= ipsum_base;
                  obase_q <= opsum_base;
                  fidx    <= '0;
                  iidx    <= '0;
                  col     <= '0;
                  col_off <= '0;
                  k       <= '0;
                  state   <= S_CFG;
               end
            end
            S_CFG:     state <= S_FILT_RD;
            S_FILT_RD: state <= S_FILT_TX;
            S_FILT_TX: begin
               if (f_acc) begin
                  fidx  <= fidx + 5'd1;
                  state <= (fidx == nf - 5'd1) ? S_IFM_RD : S_FILT_RD;
               end
            end
            S_IFM_RD:  state <= S_IFM_TX;
            S_IFM_TX: begin
               if (i_acc) begin
                  iidx <= iidx + ADDR_W'(1);
                  if (k == ifm_n - 3'd1) begin
                     k     <= '0;
                     state <= S_IPS_RD;
                  end else begin
                     k     <= k + 3'd1;
                     state <= S_IFM_RD;
                  end
               end
            end
            S_IPS_RD:  state <= S_IPS_TX;
            S_IPS_TX: begin
               if (p_acc) begin
                  if (k == np - 3'd1) begin
                     k     <= '0;
                     state <= S_OPS_RX;
                  end else begin
                     k     <= k + 3'd1;
                     state <= S_IPS_RD;
                  end
               end
            end
            S_OPS_RX: begin
               if (opsum_valid) begin
                  if (k == np - 3'd1) begin
                     k       <= '0;
                     col     <= col + 5'd1;
                     col_off <= col_off + ADDR_W'(np);
                     state   <= (col == cfg_last_col(cfg_q)) ? S_DONE : S_IFM_RD;
                  end else begin
                     k <= k + 3'd1;
                  end
               end
            end
            S_DONE:    state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Each sender loads on the first cycle of its TX state, when the read data lands.
   pe_word_tx #(.DATA_BITS(DATA_BITS)) u_filt_tx (
      .clk      (clk),
      .rst      (rst),
      .load     (rd_q && (state == S_FILT_TX)),
      .din      (buf_rd_data),
      .dout     (filter),
      .valid    (filter_valid),
      .ready    (filter_ready),
      .accepted (f_acc)
   );

   pe_word_tx #(.DATA_BITS(DATA_BITS)) u_ifm_tx (
      .clk      (clk),
      .rst      (rst),
      .load     (rd_q && (state == S_IFM_TX)),
      .din      (buf_rd_data),
      .dout     (ifmap),
      .valid    (ifmap_valid),
      .ready    (ifmap_ready),
      .accepted (i_acc)
   );

   pe_word_tx #(.DATA_BITS(DATA_BITS)) u_ips_tx (
      .clk      (clk),
      .rst      (rst),
      .load     (rd_q && (state == S_IPS_TX)),
      .din      (buf_rd_data),
      .dout     (ipsum),
      .valid    (ipsum_valid),
      .ready    (ipsum_ready),
      .accepted (p_acc)
   );

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver: transaction-level model of one PE pass plus literal timing/address pins.
module tb_pe_stream_driver;

   localparam int AW = 16;
   localparam int DB = 32;
   localparam int CS = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CS-1:0] cfg;
   logic [AW-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
   logic          busy, done;
   logic          buf_rd_en;
   logic [AW-1:0] buf_rd_addr;
   logic [DB-1:0] buf_rd_data = '0;
   logic          buf_wr_en;
   logic [AW-1:0] buf_wr_addr;
   logic [DB-1:0] buf_wr_data;
   logic          pe_en;
   logic [CS-1:0] pe_config;
   logic [DB-1:0] filter, ifmap, ipsum;
   logic          filter_valid, ifmap_valid, ipsum_valid;
   logic          filter_ready, ifmap_ready, ipsum_ready;
   logic [DB-1:0] opsum;
   logic          opsum_valid, opsum_ready;

   pe_stream_driver #(.DATA_BITS(DB), .ADDR_W(AW), .CONFIG_SIZE(CS)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg(cfg),
      .filter_base(filter_base), .ifmap_base(ifmap_base),
      .ipsum_base(ipsum_base), .opsum_base(opsum_base),
      .busy(busy), .done(done),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .pe_en(pe_en), .pe_config(pe_config),
      .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
      .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
      .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
      .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DB-1:0] mem(input logic [AW-1:0] a);
      return {16'hC0DE, a};
   endfunction

   // Global buffer read port: data one cycle after the request.
   always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem(buf_rd_addr);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @cyc %0d", name, act, exp, cyc);
      end
   endtask

   // Expected transactions for the current pass
   logic [AW-1:0] exp_rd[$];
   logic [AW-1:0] exp_wa[$];
   logic [DB-1:0] exp_wd[$];
   logic [DB-1:0] exp_f[$], exp_i[$], exp_p[$];
   logic [AW-1:0] wa_log[$];
   logic [DB-1:0] wd_log[$];
   int rd_total, wr_total, f_total, i_total, p_total;

   bit model_on = 1'b0;
   int rd_n, wr_n, f_acc, i_acc, p_acc, ops_n, done_cnt;
   int done_cyc, pe_en_cyc, rd_cyc, fv_cyc, start_cyc;
   int stall_w, stall_left;
   logic [2:0]    pv, pr;
   logic [DB-1:0] pd[3];

   task automatic build_model(input logic [CS-1:0] c, input logic [AW-1:0] fb, ib, pb, ob);
      int p, q, rs, u, ncol, np, ii, n, cnt;
      logic [AW-1:0] a;
      p    = int'(c[8:7]) + 1;
      q    = int'(c[1:0]) + 1;
      rs   = int'(c[11:10]) + 1;
      u    = int'(c[9]) + 1;
      ncol = int'(c[6:2]) + 1;
      np   = c[12] ? q : p;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      exp_f.delete(); exp_i.delete(); exp_p.delete();
      for (int i = 0; i < p * rs; i++) begin
         a = AW'(int'(fb) + i);
         exp_rd.push_back(a);
         exp_f.push_back(mem(a));
      end
      ii = 0;
      n  = 0;
      for (int col = 0; col < ncol; col++) begin
         cnt = (col == 0) ? rs : u;
         for (int j = 0; j < cnt; j++) begin
            a = AW'(int'(ib) + ii);
            ii++;
            exp_rd.push_back(a);
            exp_i.push_back(mem(a));
         end
         for (int kk = 0; kk < np; kk++) begin
            a = AW'(int'(pb) + col * np + kk);
            exp_rd.push_back(a);
            exp_p.push_back(mem(a));
         end
         for (int kk = 0; kk < np; kk++) begin
            exp_wa.push_back(AW'(int'(ob) + col * np + kk));
            exp_wd.push_back(DB'(32'hA0 + n));
            n++;
         end
      end
      rd_total = exp_rd.size();
      wr_total = exp_wa.size();
      f_total  = exp_f.size();
      i_total  = exp_i.size();
      p_total  = exp_p.size();
   endtask

   // Monitor and PE model: samples on the falling edge, decides filter_ready, then scores handshakes.
   initial forever begin
      @(negedge clk);
      if (!rst && done) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      if (!rst && model_on) begin
         if (pe_en && pe_en_cyc < 0) pe_en_cyc = cyc;
         if (buf_rd_en && rd_cyc < 0) rd_cyc = cyc;
         if (filter_valid && fv_cyc < 0) fv_cyc = cyc;
         if (pe_en) chk("busy_in_cfg", 32'(busy), 32'd1);
         if (done) chk("busy_at_done", 32'(busy), 32'd0);
         chk("one_valid", 32'($onehot0({filter_valid, ifmap_valid, ipsum_valid})), 32'd1);
         chk("rd_wr_excl", 32'(buf_rd_en & buf_wr_en), 32'd0);
         chk("wr_only_on_opsum", 32'(buf_wr_en), 32'(opsum_valid & opsum_ready));

         if (filter_valid && rd_n >= 0 && f_acc == stall_w && stall_left > 0) begin
            filter_ready = 1'b0;
            stall_left--;
         end else begin
            filter_ready = 1'b1;
         end

         if (pv[0] && !pr[0]) begin
            chk("filter_hold_vld", 32'(filter_valid), 32'd1);
            chk("filter_hold_dat", filter, pd[0]);
         end
         if (pv[1] && !pr[1]) chk("ifmap_hold_dat", ifmap, pd[1]);
         if (pv[2] && !pr[2]) chk("ipsum_hold_dat", ipsum, pd[2]);

         if (buf_rd_en) begin
            rd_n++;
            if (exp_rd.size() > 0) chk("rd_addr", 32'(buf_rd_addr), 32'(exp_rd.pop_front()));
            else chk("rd_extra", 32'(rd_n), 32'(rd_total));
         end
         if (buf_wr_en) begin
            wr_n++;
            wa_log.push_back(buf_wr_addr);
            wd_log.push_back(buf_wr_data);
            if (exp_wa.size() > 0) begin
               chk("wr_addr", 32'(buf_wr_addr), 32'(exp_wa.pop_front()));
               chk("wr_data", buf_wr_data, exp_wd.pop_front());
            end else chk("wr_extra", 32'(wr_n), 32'(wr_total));
         end
         if (filter_valid && filter_ready) begin
            f_acc++;
            if (exp_f.size() > 0) chk("filter_dat", filter, exp_f.pop_front());
            else chk("filter_extra", 32'(f_acc), 32'(f_total));
         end
         if (ifmap_valid && ifmap_ready) begin
            i_acc++;
            if (exp_i.size() > 0) chk("ifmap_dat", ifmap, exp_i.pop_front());
            else chk("ifmap_extra", 32'(i_acc), 32'(i_total));
         end
         if (ipsum_valid && ipsum_ready) begin
            p_acc++;
            if (exp_p.size() > 0) chk("ipsum_dat", ipsum, exp_p.pop_front());
            else chk("ipsum_extra", 32'(p_acc), 32'(p_total));
         end
         if (opsum_valid && opsum_ready) begin
            ops_n++;
            opsum = DB'(32'hA0 + ops_n);
         end
         pv = {ipsum_valid, ifmap_valid, filter_valid};
         pr = {ipsum_ready, ifmap_ready, filter_ready};
         pd[0] = filter;
         pd[1] = ifmap;
         pd[2] = ipsum;
      end else begin
         filter_ready = 1'b1;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_rd_en"}, 32'(buf_rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(buf_rd_addr), 32'd0);
      chk({tag, "_wr_en"}, 32'(buf_wr_en), 32'd0);
      chk({tag, "_pe_en"}, 32'(pe_en), 32'd0);
      chk({tag, "_pe_config"}, 32'(pe_config), 32'd0);
      chk({tag, "_valids"}, 32'({filter_valid, ifmap_valid, ipsum_valid}), 32'd0);
      chk({tag, "_ipsum"}, ipsum, 32'd0);
      chk({tag, "_opsum_ready"}, 32'(opsum_ready), 32'd0);
   endtask

   task automatic run(input logic [CS-1:0] c, input logic [AW-1:0] fb, ib, pb, ob,
                      input int sw, input bit glitch, input bit abort, output int dur);
      bit aborted;
      bit glitched;
      cfg = c;
      filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
      build_model(c, fb, ib, pb, ob);
      rd_n = 0; wr_n = 0; f_acc = 0; i_acc = 0; p_acc = 0; ops_n = 0; done_cnt = 0;
      done_cyc = -1; pe_en_cyc = -1; rd_cyc = -1; fv_cyc = -1;
      wa_log.delete(); wd_log.delete();
      stall_w = sw;
      stall_left = (sw >= 0) ? 5 : 0;
      pv = '0; pr = '1;
      opsum = DB'(32'hA0);
      aborted = 1'b0;
      glitched = 1'b0;
      model_on = 1'b1;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #2;
      start = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (done_cyc >= 0) break;
         if (glitch && !glitched && filter_valid) begin
            start = 1'b1;
            glitched = 1'b1;
         end else start = 1'b0;
         if (abort && ipsum_valid) begin
            model_on = 1'b0;
            rst = 1'b1;
            aborted = 1'b1;
            break;
         end
         @(negedge clk); #2;
      end
      start = 1'b0;
      dur = -1;
      if (aborted) begin
         @(negedge clk); #2;
         check_zero("abort");
         rst = 1'b0;
         repeat (3) @(negedge clk);
         #2;
         chk("abort_no_done", 32'(done_cnt), 32'd0);
         chk("abort_idle_busy", 32'(busy), 32'd0);
      end else begin
         repeat (4) @(negedge clk);
         #2;
         chk("done_cnt", 32'(done_cnt), 32'd1);
         chk("busy_after", 32'(busy), 32'd0);
         chk("pe_config", 32'(pe_config), 32'(c));
         chk("rd_left", 32'(exp_rd.size()), 32'd0);
         chk("wr_left", 32'(exp_wa.size()), 32'd0);
         chk("stream_left", 32'(exp_f.size() + exp_i.size() + exp_p.size()), 32'd0);
         dur = done_cyc - start_cyc;
      end
      model_on = 1'b0;
   endtask

   // cfg = {dw, rs-1, U-1, p-1, F, q-1}
   localparam logic [CS-1:0] C1 = {1'b0, 2'd2, 1'b0, 2'd1, 5'd0, 2'd0};
   localparam logic [CS-1:0] C3 = {1'b0, 2'd2, 1'b1, 2'd1, 5'd2, 2'd0};
   localparam logic [CS-1:0] C4 = {1'b1, 2'd2, 1'b0, 2'd0, 5'd1, 2'd3};

   initial begin
      int dur;
      rst = 1'b1; start = 1'b0; cfg = '0;
      filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
      filter_ready = 1'b1; ifmap_ready = 1'b1; ipsum_ready = 1'b1;
      opsum_valid = 1'b1; opsum = DB'(32'hA0);
      repeat (2) @(negedge clk);
      #2;
      check_zero("in_reset");
      rst = 1'b0;
      @(negedge clk); #2;
      check_zero("idle");

      // Baseline pass: 6 filter, 3 ifmap, 2 ipsum, 2 opsum writes
      run(C1, 16'h000, 16'h100, 16'h200, 16'h300, -1, 1'b0, 1'b0, dur);
      chk("t1_duration", 32'(dur), 32'd26);
      chk("t1_pe_en_at", 32'(pe_en_cyc - start_cyc), 32'd1);
      chk("t1_rd_en_at", 32'(rd_cyc - start_cyc), 32'd2);
      chk("t1_fvalid_at", 32'(fv_cyc - start_cyc), 32'd3);
      chk("t1_reads", 32'(rd_n), 32'd11);
      chk("t1_streams", 32'({f_acc[7:0], i_acc[7:0], p_acc[7:0]}), 32'h00060302);
      chk("t1_writes", 32'(wr_n), 32'd2);
      if (wa_log.size() >= 2) begin
         chk("t1_wr0_addr", 32'(wa_log[0]), 32'h300);
         chk("t1_wr0_data", wd_log[0], 32'hA0);
         chk("t1_wr1_addr", 32'(wa_log[1]), 32'h301);
         chk("t1_wr1_data", wd_log[1], 32'hA1);
      end

      // filter_ready low for 5 cycles on word 2
      run(C1, 16'h000, 16'h100, 16'h200, 16'h300, 2, 1'b0, 1'b0, dur);
      chk("t2_duration", 32'(dur), 32'd31);
      chk("t2_reads", 32'(rd_n), 32'd11);

      // U=2, F=2: three columns, ifmap continues contiguously
      run(C3, 16'h000, 16'h100, 16'h200, 16'h300, -1, 1'b0, 1'b0, dur);
      chk("t3_duration", 32'(dur), 32'd46);
      chk("t3_ifmap_words", 32'(i_acc), 32'd7);
      chk("t3_ipsum_words", 32'(p_acc), 32'd6);
      chk("t3_writes", 32'(wr_n), 32'd6);
      if (wa_log.size() >= 6) begin
         chk("t3_wr5_addr", 32'(wa_log[5]), 32'h305);
         chk("t3_wr5_data", wd_log[5], 32'hA5);
      end

      // Depthwise q=4, p=1, two columns
      run(C4, 16'h000, 16'h100, 16'h200, 16'h300, -1, 1'b0, 1'b0, dur);
      chk("t4_duration", 32'(dur), 32'd40);
      chk("t4_ipsum_words", 32'(p_acc), 32'd8);
      chk("t4_writes", 32'(wr_n), 32'd8);
      if (wa_log.size() >= 8) chk("t4_wr7_addr", 32'(wa_log[7]), 32'h307);

      // Reset during IPS_TX, then a clean pass
      run(C1, 16'h000, 16'h100, 16'h200, 16'h300, -1, 1'b0, 1'b1, dur);
      run(C1, 16'h000, 16'h100, 16'h200, 16'h300, -1, 1'b0, 1'b0, dur);
      chk("t5_duration", 32'(dur), 32'd26);

      // start pulsed during FILT_TX is ignored
      run(C1, 16'h000, 16'h100, 16'h200, 16'h300, -1, 1'b1, 1'b0, dur);
      chk("t6_duration", 32'(dur), 32'd26);

      // Address wrap at the top of the buffer
      run(C1, 16'hFFFC, 16'hFFFE, 16'hFFFF, 16'hFFFF, -1, 1'b0, 1'b0, dur);
      if (wa_log.size() >= 2) begin
         chk("t7_wr0_addr", 32'(wa_log[0]), 32'hFFFF);
         chk("t7_wr1_addr", 32'(wa_log[1]), 32'h0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
